// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Bundle of signals around the two-requester ALU arbiter.
//                It carries the requester handshake with packed per-requester
//                fields, the operand/opcode path out to the shared ALU and the
//                ALU result back, and the single response channel.
//                slave  - the arbiter's view.
//                master - the environment's view (requesters, ALU, consumer).
//  Ports       : req_valid/req_ready[1:0], req_op[7:0], req_a/req_b[2*DATA_W-1:0],
//                alu_oprd1/alu_oprd2/alu_op, alu_result/alu_zero,
//                rsp_valid/rsp_ready, rsp_id, rsp_result, rsp_zero, rsp_err
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [7:0]          req_op;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;

  logic [DATA_W-1:0]   alu_oprd1;
  logic [DATA_W-1:0]   alu_oprd2;
  logic [3:0]          alu_op;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [DATA_W-1:0]   rsp_result;
  logic                rsp_zero;
  logic                rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_oprd1, alu_oprd2, alu_op,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_oprd1, alu_oprd2, alu_op,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter that shares one combinational ALU between
//                two requesters. It routes the granted request's operands to
//                the ALU, captures the result into a one-entry response
//                register, and flags illegal opcodes.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - alu_arbiter_if.slave (requests, ALU path, response)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic              last_grant_q, last_grant_d;
  logic              rsp_valid_q,  rsp_valid_d;
  logic              rsp_id_q,     rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q,   rsp_zero_d;
  logic              rsp_err_q,    rsp_err_d;

  logic              gnt_valid;
  logic              gnt_idx;
  logic              can_accept;
  logic              xfer;
  logic              op_legal;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  // Grant is a function of req_valid and last_grant only, so req_ready has
  // no combinational path from operands or opcodes.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    case (bus.req_valid)
      2'b01: begin gnt_valid = 1'b1; gnt_idx = 1'b0;          end
      2'b10: begin gnt_valid = 1'b1; gnt_idx = 1'b1;          end
      2'b11: begin gnt_valid = 1'b1; gnt_idx = ~last_grant_q; end
      default: ;
    endcase
  end

  // The response register frees up in the same cycle it is drained.
  assign can_accept = !rsp_valid_q || bus.rsp_ready;
  assign xfer       = gnt_valid && can_accept;

  // rst is included so nothing is accepted while the block is held in reset.
  assign bus.req_ready = (xfer && !rst) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  assign sel_op = gnt_idx ? bus.req_op[7:4]          : bus.req_op[3:0];
  assign sel_a  = gnt_idx ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
  assign sel_b  = gnt_idx ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];

  // Drive zeros when idle so the shared ALU never sees X.
  assign bus.alu_op    = gnt_valid ? sel_op : 4'b0000;
  assign bus.alu_oprd1 = gnt_valid ? sel_a  : '0;
  assign bus.alu_oprd2 = gnt_valid ? sel_b  : '0;

  always_comb begin
    case (sel_op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    if (xfer) begin
      // A new transfer overwrites a response drained this cycle: no bubble.
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt_idx;
      last_grant_d = gnt_idx;
      rsp_result_d = op_legal ? bus.alu_result : '0;
      rsp_zero_d   = op_legal && bus.alu_zero;
      rsp_err_d    = !op_legal;
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed bench for alu_arbiter. A small combinational ALU
//                model answers the arbiter's ALU port; each scenario task
//                drives requests and compares outputs against hand-computed
//                values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(32)) bus ();

  alu_arbiter #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External ALU. Unknown opcodes return a non-zero pattern so that an
  // arbiter leaking the ALU result on an illegal op is visible.
  logic [31:0] alu_r;
  always_comb begin
    alu_r = 32'h0;
    case (bus.alu_op)
      4'b0010: alu_r = bus.alu_oprd1 + bus.alu_oprd2;
      4'b0110: alu_r = bus.alu_oprd1 - bus.alu_oprd2;
      4'b0000: alu_r = bus.alu_oprd1 & bus.alu_oprd2;
      4'b0001: alu_r = bus.alu_oprd1 | bus.alu_oprd2;
      4'b1100: alu_r = ~(bus.alu_oprd1 | bus.alu_oprd2);
      4'b0111: alu_r = ($signed(bus.alu_oprd1) < $signed(bus.alu_oprd2)) ? 32'd1 : 32'd0;
      default: alu_r = 32'hDEADBEEF;
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_zero   = (alu_r == 32'h0);

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]     = v;
    bus.req_op[4*i +: 4] = op;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'b0010, 32'd1, 32'd1);
    set_req(1, 1'b1, 4'b0010, 32'd2, 32'd2);
    #3;
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%0h exp=0", bus.rsp_valid); else passed++;
    total++; if (bus.rsp_id !== 1'b0) $display("FAIL reset_rsp_id got=%0h exp=0", bus.rsp_id); else passed++;
    total++; if (bus.rsp_result !== 32'h0) $display("FAIL reset_rsp_result got=%0h exp=0", bus.rsp_result); else passed++;
    total++; if (bus.rsp_zero !== 1'b0) $display("FAIL reset_rsp_zero got=%0h exp=0", bus.rsp_zero); else passed++;
    total++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%0h exp=0", bus.rsp_err); else passed++;
    tick();
    total++; if (bus.req_ready !== 2'b00) $display("FAIL reset_req_ready got=%0b exp=00", bus.req_ready); else passed++;
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_hold_valid got=%0h exp=0", bus.rsp_valid); else passed++;
    set_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'b0000, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_contention;
    rst = 1'b0;
    set_req(0, 1'b1, 4'b0010, 32'd5, 32'd7);
    set_req(1, 1'b1, 4'b0110, 32'd3, 32'd3);
    #1;
    total++; if (bus.req_ready !== 2'b01) $display("FAIL cont_ready0 got=%0b exp=01", bus.req_ready); else passed++;
    total++; if (bus.alu_oprd1 !== 32'd5 || bus.alu_op !== 4'b0010) $display("FAIL cont_alu_mux got=%0h/%0b exp=5/0010", bus.alu_oprd1, bus.alu_op); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0) $display("FAIL cont_rsp1_id got=%0h/%0h exp=1/0", bus.rsp_valid, bus.rsp_id); else passed++;
    total++; if (bus.rsp_result !== 32'd12 || bus.rsp_zero !== 1'b0) $display("FAIL cont_rsp1_data got=%0h/%0h exp=c/0", bus.rsp_result, bus.rsp_zero); else passed++;
    total++; if (bus.req_ready !== 2'b10) $display("FAIL cont_ready1 got=%0b exp=10", bus.req_ready); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1) $display("FAIL cont_rsp2_id got=%0h/%0h exp=1/1", bus.rsp_valid, bus.rsp_id); else passed++;
    total++; if (bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b1) $display("FAIL cont_rsp2_data got=%0h/%0h exp=0/1", bus.rsp_result, bus.rsp_zero); else passed++;
    set_req(0, 1'b0, 4'b0010, 32'd5, 32'd7);
    set_req(1, 1'b0, 4'b0110, 32'd3, 32'd3);
    #1;
    total++; if (bus.alu_op !== 4'b0000 || bus.alu_oprd1 !== 32'h0 || bus.alu_oprd2 !== 32'h0) $display("FAIL idle_alu_zero got=%0b/%0h/%0h exp=0000/0/0", bus.alu_op, bus.alu_oprd1, bus.alu_oprd2); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL cont_drain got=%0h exp=0", bus.rsp_valid); else passed++;
  endtask

  task automatic test_fairness;
    set_req(0, 1'b1, 4'b0010, 32'd10, 32'd1);
    set_req(1, 1'b1, 4'b0110, 32'd10, 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (bus.rsp_id !== k[0]) $display("FAIL fair_id%0d got=%0h exp=%0h", k, bus.rsp_id, k[0]); else passed++;
      total++; if (bus.rsp_result !== (k[0] ? 32'd9 : 32'd11)) $display("FAIL fair_res%0d got=%0h exp=%0h", k, bus.rsp_result, (k[0] ? 32'd9 : 32'd11)); else passed++;
    end
    set_req(0, 1'b0, 4'b0010, 32'd10, 32'd1);
    set_req(1, 1'b0, 4'b0110, 32'd10, 32'd1);
    tick();
  endtask

  task automatic test_backpressure;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'b0001, 32'hF0, 32'h0F);
    #1;
    total++; if (bus.req_ready !== 2'b01) $display("FAIL bp_ready_first got=%0b exp=01", bus.req_ready); else passed++;
    tick();
    set_req(0, 1'b0, 4'b0001, 32'hF0, 32'h0F);
    set_req(1, 1'b1, 4'b0010, 32'd1, 32'd1);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (bus.req_ready !== 2'b00) $display("FAIL bp_ready_stall%0d got=%0b exp=00", c, bus.req_ready); else passed++;
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'hFF) $display("FAIL bp_hold%0d got=%0h/%0h/%0h exp=1/0/ff", c, bus.rsp_valid, bus.rsp_id, bus.rsp_result); else passed++;
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b10) $display("FAIL bp_ready_drain got=%0b exp=10", bus.req_ready); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_result !== 32'd2) $display("FAIL bp_next got=%0h/%0h/%0h exp=1/1/2", bus.rsp_valid, bus.rsp_id, bus.rsp_result); else passed++;
    set_req(1, 1'b0, 4'b0010, 32'd1, 32'd1);
    tick();
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_drain got=%0h exp=0", bus.rsp_valid); else passed++;
  endtask

  task automatic test_illegal;
    set_req(1, 1'b1, 4'b1111, 32'd5, 32'd6);
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1) $display("FAIL ill_id got=%0h/%0h exp=1/1", bus.rsp_valid, bus.rsp_id); else passed++;
    total++; if (bus.rsp_err !== 1'b1 || bus.rsp_result !== 32'h0 || bus.rsp_zero !== 1'b0) $display("FAIL ill_data got=%0h/%0h/%0h exp=1/0/0", bus.rsp_err, bus.rsp_result, bus.rsp_zero); else passed++;
    set_req(1, 1'b0, 4'b1111, 32'd5, 32'd6);
    set_req(0, 1'b1, 4'b0000, 32'hFF, 32'h0F);
    tick();
    total++; if (bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_result !== 32'h0F) $display("FAIL ill_next got=%0h/%0h/%0h exp=0/0/f", bus.rsp_id, bus.rsp_err, bus.rsp_result); else passed++;
    set_req(0, 1'b0, 4'b0000, 32'hFF, 32'h0F);
    tick();
  endtask

  task automatic test_slt;
    set_req(0, 1'b1, 4'b0111, 32'hFFFFFFFF, 32'd1);
    tick();
    total++; if (bus.rsp_result !== 32'd1 || bus.rsp_zero !== 1'b0) $display("FAIL slt_neg got=%0h/%0h exp=1/0", bus.rsp_result, bus.rsp_zero); else passed++;
    set_req(0, 1'b1, 4'b0111, 32'd1, 32'hFFFFFFFF);
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b1) $display("FAIL slt_pos got=%0h/%0h/%0h exp=1/0/1", bus.rsp_valid, bus.rsp_result, bus.rsp_zero); else passed++;
    set_req(0, 1'b0, 4'b0111, 32'd1, 32'hFFFFFFFF);
    tick();
  endtask

  task automatic test_async_reset;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'b0010, 32'd2, 32'd2);
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd4) $display("FAIL ar_pre got=%0h/%0h exp=1/4", bus.rsp_valid, bus.rsp_result); else passed++;
    #2;
    rst           = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'b0010, 32'd3, 32'd3);
    set_req(1, 1'b1, 4'b0110, 32'd9, 32'd1);
    #1;
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'h0) $display("FAIL ar_clear got=%0h/%0h exp=0/0", bus.rsp_valid, bus.rsp_result); else passed++;
    total++; if (bus.req_ready !== 2'b00) $display("FAIL ar_ready got=%0b exp=00", bus.req_ready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.req_ready !== 2'b01) $display("FAIL ar_first_grant got=%0b exp=01", bus.req_ready); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'd6) $display("FAIL ar_rsp got=%0h/%0h/%0h exp=1/0/6", bus.rsp_valid, bus.rsp_id, bus.rsp_result); else passed++;
    set_req(0, 1'b0, 4'b0010, 32'd3, 32'd3);
    set_req(1, 1'b0, 4'b0110, 32'd9, 32'd1);
    tick();
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_op    = 8'h00;
    bus.req_a     = 64'h0;
    bus.req_b     = 64'h0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_contention();
    test_fairness();
    test_backpressure();
    test_illegal();
    test_slt();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
